// File: rtl/reg_file.sv
// Register file with two combinational read ports, one write port, and ALU flags with a shadow copy.
// Optional same-cycle write/flag bypass is compiled in when REG_FILE_BYPASS_EN is defined.
module reg_file #(
    parameter int unsigned DW   = 8,
    parameter int unsigned NREG = 8,
    localparam int unsigned AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          flags_we,
    input  logic [2:0]    flags_in,
    input  logic          flags_save,
    input  logic          flags_restore,
    output logic [2:0]    flags_out,
    output logic          wr_conflict
);

    localparam logic [AW:0] NREG_W = NREG[AW:0];

    logic [DW-1:0] regs_q [NREG];
    logic [2:0]    flags_q, flags_d;
    logic [2:0]    shadow_q, shadow_d;
    logic          conflict_q, conflict_d;
    logic          waddr_ok;
    logic          wr_ok;
    logic          ra_ok, rb_ok;
    logic [DW-1:0] stored_a, stored_b;

    assign waddr_ok = ({1'b0, waddr} < NREG_W);
    assign wr_ok    = we && waddr_ok;
    assign ra_ok    = ({1'b0, raddr_a} < NREG_W);
    assign rb_ok    = ({1'b0, raddr_b} < NREG_W);

    // Out-of-range reads return zero rather than an undefined array element.
    assign stored_a = ra_ok ? regs_q[raddr_a] : '0;
    assign stored_b = rb_ok ? regs_q[raddr_b] : '0;

    always_comb begin
        flags_d = flags_q;
        if (flags_restore) begin
            flags_d = shadow_q;
        end else if (flags_we) begin
            flags_d = flags_in;
        end
    end

    // Save takes the pre-edge live value, so save+restore together swaps the two.
    always_comb begin
        shadow_d = shadow_q;
        if (flags_save) begin
            shadow_d = flags_q;
        end
    end

    always_comb begin
        conflict_d = conflict_q | (flags_we & flags_restore) | (we & ~waddr_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            flags_q    <= '0;
            shadow_q   <= '0;
            conflict_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs_q[waddr] <= wdata;
            end
            flags_q    <= flags_d;
            shadow_q   <= shadow_d;
            conflict_q <= conflict_d;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    always_comb begin
        rdata_a   = (wr_ok && (raddr_a == waddr)) ? wdata : stored_a;
        rdata_b   = (wr_ok && (raddr_b == waddr)) ? wdata : stored_b;
        flags_out = (flags_we && !flags_restore) ? flags_in : flags_q;
    end
`else
    always_comb begin
        rdata_a   = stored_a;
        rdata_b   = stored_b;
        flags_out = flags_q;
    end
`endif

    assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REG_FILE_BYPASS_EN when defined.
module tb_reg_file;

    localparam int unsigned DW   = 8;
    localparam int unsigned NREG = 8;
    localparam int unsigned AW   = 3;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] raddr_a, raddr_b, waddr;
    logic [DW-1:0] rdata_a, rdata_b, wdata;
    logic          we, flags_we, flags_save, flags_restore, wr_conflict;
    logic [2:0]    flags_in, flags_out;

    int checks = 0;
    int errors = 0;

    reg_file #(.DW(DW), .NREG(NREG)) dut (
        .clk           (clk),
        .reset         (reset),
        .raddr_a       (raddr_a),
        .raddr_b       (raddr_b),
        .rdata_a       (rdata_a),
        .rdata_b       (rdata_b),
        .we            (we),
        .waddr         (waddr),
        .wdata         (wdata),
        .flags_we      (flags_we),
        .flags_in      (flags_in),
        .flags_save    (flags_save),
        .flags_restore (flags_restore),
        .flags_out     (flags_out),
        .wr_conflict   (wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle inputs away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; we = 1'b0; flags_we = 1'b0; flags_save = 1'b0; flags_restore = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        raddr_a = '0; raddr_b = '0; waddr = '0; wdata = '0; flags_in = '0;
        // Dirty some state before reset to show reset clears it.
        we = 1'b1; waddr = 3'd2; wdata = 8'h77;
        tick();
        tick();
        idle();

        // Reset state across all addresses.
        for (int i = 0; i < int'(NREG); i++) begin
            raddr_a = AW'(i);
            raddr_b = AW'(NREG - 1 - i);
            #1;
            check($sformatf("rst_rd_a%0d", i), 32'(rdata_a), 32'h00);
            check($sformatf("rst_rd_b%0d", i), 32'(rdata_b), 32'h00);
        end
        check("rst_flags", 32'(flags_out), 32'h0);
        check("rst_conflict", 32'(wr_conflict), 32'h0);

        // Basic write then read on both ports.
        we = 1'b1; waddr = 3'd3; wdata = 8'hA5;
        tick();
        idle();
        raddr_a = 3'd3; raddr_b = 3'd3; #1;
        check("wr_r3_a", 32'(rdata_a), 32'hA5);
        check("wr_r3_b", 32'(rdata_b), 32'hA5);
        raddr_a = 3'd2; raddr_b = 3'd4; #1;
        check("r2_hold", 32'(rdata_a), 32'h00);
        check("r4_hold", 32'(rdata_b), 32'h00);

        // Same-cycle read of a pending write.
        we = 1'b1; waddr = 3'd5; wdata = 8'h3C; raddr_a = 3'd5; raddr_b = 3'd3; #1;
        check("pend_r5", 32'(rdata_a), BYPASS ? 32'h3C : 32'h00);
        check("pend_r3_other", 32'(rdata_b), 32'hA5);
        tick();
        idle();
        check("after_r5", 32'(rdata_a), 32'h3C);

        // Write to r0 and check neighbours untouched.
        we = 1'b1; waddr = 3'd0; wdata = 8'h5A;
        tick();
        idle();
        raddr_a = 3'd0; raddr_b = 3'd1; #1;
        check("wr_r0", 32'(rdata_a), 32'h5A);
        check("r1_hold", 32'(rdata_b), 32'h00);

        // Flags: live=100, then save with simultaneous flag write.
        flags_we = 1'b1; flags_in = 3'b100;
        tick();
        idle();
        check("flags_100", 32'(flags_out), 32'b100);
        flags_save = 1'b1; flags_we = 1'b1; flags_in = 3'b011; #1;
        check("flags_byp", 32'(flags_out), BYPASS ? 32'b011 : 32'b100);
        tick();
        idle();
        check("flags_011", 32'(flags_out), 32'b011);
        flags_restore = 1'b1;
        tick();
        idle();
        check("restore_100", 32'(flags_out), 32'b100);
        check("no_conflict", 32'(wr_conflict), 32'h0);

        // Swap: live=010, shadow=100.
        flags_we = 1'b1; flags_in = 3'b010;
        tick();
        idle();
        flags_save = 1'b1; flags_restore = 1'b1;
        tick();
        idle();
        check("swap_live", 32'(flags_out), 32'b100);
        flags_restore = 1'b1;
        tick();
        idle();
        check("swap_shadow", 32'(flags_out), 32'b010);

        // Conflict: live=001, shadow=010, then write+restore together.
        flags_we = 1'b1; flags_in = 3'b001;
        tick();
        idle();
        flags_we = 1'b1; flags_in = 3'b111; flags_restore = 1'b1;
        tick();
        idle();
        check("conf_flags", 32'(flags_out), 32'b010);
        check("conf_set", 32'(wr_conflict), 32'h1);
        tick();
        tick();
        tick();
        check("conf_sticky", 32'(wr_conflict), 32'h1);

        // Reset wins over a simultaneous write, save and flag update.
        we = 1'b1; waddr = 3'd7; wdata = 8'hFF;
        tick();
        idle();
        raddr_a = 3'd7; raddr_b = 3'd3; #1;
        check("wr_r7", 32'(rdata_a), 32'hFF);
        reset = 1'b1; we = 1'b1; waddr = 3'd7; wdata = 8'h11;
        flags_we = 1'b1; flags_in = 3'b111; flags_save = 1'b1;
        tick();
        idle();
        check("rst_r7", 32'(rdata_a), 32'h00);
        check("rst_r3", 32'(rdata_b), 32'h00);
        check("rst2_flags", 32'(flags_out), 32'h0);
        check("rst2_conflict", 32'(wr_conflict), 32'h0);
        flags_restore = 1'b1;
        tick();
        idle();
        check("rst_shadow", 32'(flags_out), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
